// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    localparam logic [3:0] BMASK_NONE = 4'b0000;

    // Counter width is fixed by the largest legal read latency so the package stays parameter-free.
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority winner select: LSU first, unless the starvation guard hands the slot to fetch.
module arb_prio_sel (
    input  logic if_elig,
    input  logic ls_req,
    input  logic starve_hit,
    output logic pick_if,
    output logic pick_ls
);

    always_comb begin
        pick_ls = ls_req & ~(if_elig & starve_hit);
        pick_if = if_elig & ~pick_ls;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter sharing one synchronous SRAM between fetch and the LSU.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    state_t              state, state_nxt;
    owner_t              owner;
    logic [CNT_W-1:0]    cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                drop;

    logic if_elig, starve_hit, pick_if, pick_ls;
    logic arb_en, gnt_if, gnt_ls, issue_rd, done;

    assign if_elig    = i_if_req & ~i_if_flush;
    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));
    // Reset gates arbitration so no grant can leak out while i_reset is low.
    assign arb_en     = (state == IDLE) & i_reset;
    assign gnt_if     = arb_en & pick_if;
    assign gnt_ls     = arb_en & pick_ls;
    assign issue_rd   = gnt_if | (gnt_ls & ~i_ls_we);
    assign done       = (state == WAIT) && (cnt == '0);

    arb_prio_sel u_sel (
        .if_elig    (if_elig),
        .ls_req     (i_ls_req),
        .starve_hit (starve_hit),
        .pick_if    (pick_if),
        .pick_ls    (pick_ls)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_rd) state_nxt = WAIT;
            WAIT:    if (done)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            owner      <= OWN_IF;
            cnt        <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
        end else begin
            if (issue_rd) begin
                owner <= gnt_ls ? OWN_LS : OWN_IF;
                cnt   <= CNT_W'(MEM_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == WAIT) begin
                if (done) drop <= 1'b0;
                else if (owner == OWN_IF && i_if_flush) drop <= 1'b1;
            end

            if (arb_en) begin
                if (gnt_if || !if_elig) starve_cnt <= '0;
                else if (gnt_ls && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_if_gnt    = gnt_if;
        o_ls_gnt    = gnt_ls;
        o_mem_en    = gnt_if | gnt_ls;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = BMASK_NONE;
        if (gnt_ls) begin
            o_mem_we    = i_ls_we;
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_wdata;
            o_mem_bmask = i_ls_bmask;
        end else if (gnt_if) begin
            o_mem_addr = i_if_addr;
        end
        // A flush landing on the return cycle itself also suppresses the fetch response.
        o_if_rvalid = done & (owner == OWN_IF) & ~drop & ~i_if_flush;
        o_ls_rvalid = done & (owner == OWN_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: four arbiter instances (MEM_LAT 1..4) share stimulus; each scenario checks one instance.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_flush, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;

    logic        if_gnt[4], if_rvalid[4], ls_gnt[4], ls_rvalid[4];
    logic        mem_en[4], mem_we[4];
    logic [31:0] if_rdata[4], ls_rdata[4], mem_addr[4], mem_wdata[4];
    logic [3:0]  mem_bmask[4];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (g + 1),
            .STARVE_MAX (4)
        ) u_dut (
            .i_clk       (clk),
            .i_reset     (rst_n),
            .i_if_req    (if_req),
            .i_if_addr   (if_addr),
            .i_if_flush  (if_flush),
            .o_if_gnt    (if_gnt[g]),
            .o_if_rvalid (if_rvalid[g]),
            .o_if_rdata  (if_rdata[g]),
            .i_ls_req    (ls_req),
            .i_ls_we     (ls_we),
            .i_ls_addr   (ls_addr),
            .i_ls_wdata  (ls_wdata),
            .i_ls_bmask  (ls_bmask),
            .o_ls_gnt    (ls_gnt[g]),
            .o_ls_rvalid (ls_rvalid[g]),
            .o_ls_rdata  (ls_rdata[g]),
            .o_mem_en    (mem_en[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .o_mem_bmask (mem_bmask[g]),
            .i_mem_rdata (mem_rdata)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
        mem_rdata = '0;
    endtask

    // Leaves the bench at the start of cycle 0, reset just released, all inputs idle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        // Reset: outputs quiet even with a fetch request pending.
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0000_0020;
        sample();
        chk("rst_if_gnt", 32'(if_gnt[0]), 32'd0);
        chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        next_cycle();
        if_req = 1'b0;
        rst_n = 1'b1;
        sample();
        chk("rel_mem_en", 32'(mem_en[0]), 32'd0);
        chk("rel_if_rvalid", 32'(if_rvalid[0]), 32'd0);

        // Single fetch, MEM_LAT=1.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h0000_0093;
        sample();
        chk("f1_gnt", 32'(if_gnt[0]), 32'd1);
        chk("f1_mem_en", 32'(mem_en[0]), 32'd1);
        chk("f1_mem_addr", mem_addr[0], 32'h0000_0010);
        chk("f1_mem_we", 32'(mem_we[0]), 32'd0);
        chk("f1_mem_bmask", 32'(mem_bmask[0]), 32'd0);
        chk("f1_rvalid_c0", 32'(if_rvalid[0]), 32'd0);
        next_cycle();
        if_req = 1'b0;
        sample();
        chk("f1_rvalid_c1", 32'(if_rvalid[0]), 32'd1);
        chk("f1_rdata_c1", if_rdata[0], 32'h0000_0093);
        chk("f1_mem_en_c1", 32'(mem_en[0]), 32'd0);
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0000_0014;
        sample();
        chk("f1_rvalid_c2", 32'(if_rvalid[0]), 32'd0);
        chk("f1_rdata_c2", if_rdata[0], 32'd0);
        chk("f1_idle_gnt_c2", 32'(if_gnt[0]), 32'd1);

        // LSU store then load back-to-back.
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_7000;
        ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b1111;
        sample();
        chk("st_gnt", 32'(ls_gnt[0]), 32'd1);
        chk("st_mem_en", 32'(mem_en[0]), 32'd1);
        chk("st_mem_we", 32'(mem_we[0]), 32'd1);
        chk("st_mem_addr", mem_addr[0], 32'h0000_7000);
        chk("st_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        chk("st_mem_bmask", 32'(mem_bmask[0]), 32'hF);
        next_cycle();
        ls_we = 1'b0; ls_addr = 32'h0000_7004; ls_bmask = 4'b0000;
        sample();
        chk("ld_gnt_next", 32'(ls_gnt[0]), 32'd1);
        chk("st_no_rvalid", 32'(ls_rvalid[0]), 32'd0);
        chk("ld_mem_we", 32'(mem_we[0]), 32'd0);
        next_cycle();
        ls_req = 1'b0; mem_rdata = 32'h1234_5678;
        sample();
        chk("ld_rvalid", 32'(ls_rvalid[0]), 32'd1);
        chk("ld_rdata", ls_rdata[0], 32'h1234_5678);
        chk("ld_if_rvalid", 32'(if_rvalid[0]), 32'd0);

        // Contention with LSU stores: LS x4, IF, (wait), LS.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0200; ls_bmask = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) next_cycle();
            sample();
            chk($sformatf("ct_ls_gnt_%0d", k), 32'(ls_gnt[0]), (k < 4 || k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("ct_if_gnt_%0d", k), 32'(if_gnt[0]), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) chk("ct_if_addr", mem_addr[0], 32'h0000_0100);
        end

        // Flush during a MEM_LAT=3 fetch drops the response but waits out the latency.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h0000_00AB;
        sample();
        chk("fl_gnt_c0", 32'(if_gnt[2]), 32'd1);
        next_cycle();
        if_req = 1'b0; if_flush = 1'b1;
        sample();
        chk("fl_rvalid_c1", 32'(if_rvalid[2]), 32'd0);
        next_cycle();
        if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0044;
        sample();
        chk("fl_gnt_c2", 32'(if_gnt[2]), 32'd0);
        next_cycle();
        sample();
        chk("fl_rvalid_c3", 32'(if_rvalid[2]), 32'd0);
        chk("fl_rdata_c3", if_rdata[2], 32'd0);
        chk("fl_gnt_c3", 32'(if_gnt[2]), 32'd0);
        next_cycle();
        sample();
        chk("fl_gnt_c4", 32'(if_gnt[2]), 32'd1);
        chk("fl_addr_c4", mem_addr[2], 32'h0000_0044);
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("fl_rvalid_c7", 32'(if_rvalid[2]), 32'd1);
        chk("fl_rdata_c7", if_rdata[2], 32'h0000_00AB);

        // Async reset at issue+1 of a MEM_LAT=2 fetch.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0080; mem_rdata = 32'h0000_0055;
        sample();
        chk("ra_gnt_c0", 32'(if_gnt[1]), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        sample();
        chk("ra_gnt_in_rst", 32'(if_gnt[1]), 32'd0);
        chk("ra_mem_en_in_rst", 32'(mem_en[1]), 32'd0);
        next_cycle();
        sample();
        chk("ra_rvalid_in_rst", 32'(if_rvalid[1]), 32'd0);
        chk("ra_rdata_in_rst", if_rdata[1], 32'd0);
        next_cycle();
        rst_n = 1'b1; if_addr = 32'h0000_0084;
        sample();
        chk("ra_gnt_after_rel", 32'(if_gnt[1]), 32'd1);
        chk("ra_rvalid_after_rel", 32'(if_rvalid[1]), 32'd0);
        chk("ra_addr_after_rel", mem_addr[1], 32'h0000_0084);
        next_cycle();
        if_req = 1'b0;
        sample();
        chk("ra_rvalid_c1_after", 32'(if_rvalid[1]), 32'd0);

        // MEM_LAT=4 load with fetch held: rvalid at grant+4, fetch never granted meanwhile.
        do_reset();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_1004;
        if_req = 1'b1; if_addr = 32'h0000_2000;
        sample();
        chk("l4_ls_gnt", 32'(ls_gnt[3]), 32'd1);
        chk("l4_if_gnt_c0", 32'(if_gnt[3]), 32'd0);
        chk("l4_mem_addr", mem_addr[3], 32'h0000_1004);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            ls_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
            sample();
            chk($sformatf("l4_if_gnt_%0d", k), 32'(if_gnt[3]), 32'd0);
            chk($sformatf("l4_rvalid_%0d", k), 32'(ls_rvalid[3]), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("l4_rdata_%0d", k), ls_rdata[3], (k == 4) ? 32'hCAFE_F00D : 32'd0);
        end
        next_cycle();
        sample();
        chk("l4_if_gnt_c5", 32'(if_gnt[3]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
